// File: rtl/ret_stack_ctrl.sv
// ret_stack_ctrl: circular return-address stack with registered return-target prediction
// Ports: clk/rst (async active-low) | stall, push_en/push_addr (call), pop_en (return)
//        flush/flush_sp/flush_cnt/flush_top (mispredict repair)
//        pred_valid/pred_addr (registered prediction), snap_sp/snap_cnt (checkpoint)
//        empty/full (combinational), underflow (one-cycle pulse)
// Build option: RSTACK_REPAIR_EN also restores the top entry from flush_top on flush.
module ret_stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int IP_WIDTH = 48,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                push_en,
    input  logic [IP_WIDTH-1:0] push_addr,
    input  logic                pop_en,
    input  logic                flush,
    input  logic [PTR_W-1:0]    flush_sp,
    input  logic [PTR_W:0]      flush_cnt,
    input  logic [IP_WIDTH-1:0] flush_top,
    output logic                pred_valid,
    output logic [IP_WIDTH-1:0] pred_addr,
    output logic [PTR_W-1:0]    snap_sp,
    output logic [PTR_W:0]      snap_cnt,
    output logic                empty,
    output logic                full,
    output logic                underflow
);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] SP_RST  = PTR_W'(DEPTH-1);
    logic [IP_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_sp;
    logic [PTR_W:0]      r_cnt;
    logic                r_pred_valid;
    logic [IP_WIDTH-1:0] r_pred_addr;
    logic                r_underflow;
    logic                w_push;
    logic                w_pop;
    logic                w_we;
    logic [PTR_W-1:0]    w_waddr;
    logic [IP_WIDTH-1:0] w_wdata;
    logic [PTR_W-1:0]    w_sp_nx;
    logic [PTR_W:0]      w_cnt_nx;
    logic                w_pv_nx;
    logic                w_uf_nx;
    logic [IP_WIDTH-1:0] w_pred_nx;
    assign w_push     = !stall && push_en;
    assign w_pop      = !stall && pop_en;
    assign empty      = r_cnt == '0;
    assign full       = r_cnt == CNT_MAX;
    assign snap_sp    = r_sp;
    assign snap_cnt   = r_cnt;
    assign pred_valid = r_pred_valid;
    assign pred_addr  = r_pred_addr;
    assign underflow  = r_underflow;
`ifndef RSTACK_REPAIR_EN
    logic w_unused;
    assign w_unused = ^flush_top;
`endif
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_sp + 1'b1;
        w_wdata   = push_addr;
        w_sp_nx   = r_sp;
        w_cnt_nx  = r_cnt;
        w_pv_nx   = 1'b0;
        w_uf_nx   = 1'b0;
        w_pred_nx = r_pred_addr;
        if (flush) begin
            w_sp_nx  = flush_sp;
            w_cnt_nx = flush_cnt > CNT_MAX ? CNT_MAX : flush_cnt;
`ifdef RSTACK_REPAIR_EN
            w_we     = flush_cnt != '0;
            w_waddr  = flush_sp;
            w_wdata  = flush_top;
`endif
        end else if (w_push && w_pop && !empty) begin
            // swap the top: predict the old value, then overwrite it in place
            w_pred_nx = r_mem[r_sp];
            w_pv_nx   = 1'b1;
            w_we      = 1'b1;
            w_waddr   = r_sp;
        end else if (w_push) begin
            // a full stack wraps and silently drops its oldest entry
            w_we     = 1'b1;
            w_sp_nx  = r_sp + 1'b1;
            w_cnt_nx = full ? r_cnt : r_cnt + 1'b1;
            w_uf_nx  = w_pop;
        end else if (w_pop) begin
            w_pred_nx = empty ? r_pred_addr : r_mem[r_sp];
            w_pv_nx   = !empty;
            w_uf_nx   = empty;
            w_sp_nx   = empty ? r_sp : r_sp - 1'b1;
            w_cnt_nx  = empty ? r_cnt : r_cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp         <= SP_RST;
            r_cnt        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_addr  <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_sp         <= w_sp_nx;
            r_cnt        <= w_cnt_nx;
            r_pred_valid <= w_pv_nx;
            r_pred_addr  <= w_pred_nx;
            r_underflow  <= w_uf_nx;
        end
    end
endmodule

// File: tb/tb_ret_stack_ctrl.sv
// tb_ret_stack_ctrl: scoreboard bench for the return-address stack controller
module tb_ret_stack_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        push_en = 1'b0;
    logic [47:0] push_addr = '0;
    logic        pop_en = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  flush_sp = '0;
    logic [4:0]  flush_cnt = '0;
    logic [47:0] flush_top = '0;
    logic        pred_valid;
    logic [47:0] pred_addr;
    logic [3:0]  snap_sp;
    logic [4:0]  snap_cnt;
    logic        empty;
    logic        full;
    logic        underflow;
    logic [47:0] q [$];
    int n_vec = 0;
    int n_err = 0;

    ret_stack_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .push_en(push_en), .push_addr(push_addr),
        .pop_en(pop_en), .flush(flush), .flush_sp(flush_sp), .flush_cnt(flush_cnt),
        .flush_top(flush_top), .pred_valid(pred_valid), .pred_addr(pred_addr),
        .snap_sp(snap_sp), .snap_cnt(snap_cnt), .empty(empty), .full(full),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // every prediction the DUT emits must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && pred_valid === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL pred_unexpected: got addr %h, expected no prediction", pred_addr);
            end else begin
                logic [47:0] e;
                e = q.pop_front();
                if (pred_addr !== e) begin
                    n_err++;
                    $display("FAIL pred_addr: got %h, expected %h", pred_addr, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        stall = 1'b0;
        push_en = 1'b0;
        pop_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic push(input logic [47:0] a);
        push_en = 1'b1;
        push_addr = a;
        step();
    endtask

    task automatic pop(input logic [47:0] e);
        pop_en = 1'b1;
        q.push_back(e);
        step();
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d predictions missing, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_vec++;
        if ({pred_valid, underflow, empty, full, snap_sp, snap_cnt, pred_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 5'd0, 48'h0}) begin
            n_err++;
            $display("FAIL reset_state: got pv=%b uf=%b e=%b f=%b sp=%0d cnt=%0d pa=%h, expected 0 0 1 0 15 0 0",
                     pred_valid, underflow, empty, full, snap_sp, snap_cnt, pred_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_lifo();
        do_reset();
        push(48'h1000);
        push(48'h2000);
        push(48'h3000);
        n_vec++;
        if (snap_sp !== 4'd2 || snap_cnt !== 5'd3) begin
            n_err++;
            $display("FAIL lifo_snap: got sp=%0d cnt=%0d, expected 2 3", snap_sp, snap_cnt);
        end
        pop(48'h3000);
        pop(48'h2000);
        pop(48'h1000);
        drain("lifo");
        n_vec++;
        if (empty !== 1'b1 || snap_sp !== 4'd15) begin
            n_err++;
            $display("FAIL lifo_empty: got empty=%b sp=%0d, expected 1 15", empty, snap_sp);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) push(48'h100 + 48'(i));
        n_vec++;
        if (full !== 1'b1 || snap_cnt !== 5'd16) begin
            n_err++;
            $display("FAIL wrap_full: got full=%b cnt=%0d, expected 1 16", full, snap_cnt);
        end
        for (int i = 0; i < 16; i++) pop(48'h110 - 48'(i));
        drain("wrap");
        pop_en = 1'b1;
        step();
        n_vec++;
        if (pred_valid !== 1'b0 || underflow !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_underflow: got pv=%b uf=%b, expected 0 1", pred_valid, underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        pop_en = 1'b1;
        step();
        n_vec++;
        if (underflow !== 1'b1 || snap_sp !== 4'd15 || snap_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL uf_pulse: got uf=%b sp=%0d cnt=%0d, expected 1 15 0", underflow, snap_sp, snap_cnt);
        end
        step();
        n_vec++;
        if (underflow !== 1'b0) begin
            n_err++;
            $display("FAIL uf_oneshot: got uf=%b, expected 0", underflow);
        end
        stall = 1'b1;
        pop_en = 1'b1;
        step();
        n_vec++;
        if (underflow !== 1'b0 || snap_sp !== 4'd15 || snap_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL uf_stall: got uf=%b sp=%0d cnt=%0d, expected 0 15 0", underflow, snap_sp, snap_cnt);
        end
        stall = 1'b1;
        push_en = 1'b1;
        push_addr = 48'hBAD;
        step();
        n_vec++;
        if (snap_cnt !== 5'd0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL stall_push: got cnt=%0d empty=%b, expected 0 1", snap_cnt, empty);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        push(48'hA);
        push(48'hB);
        push_en = 1'b1;
        push_addr = 48'hC;
        pop_en = 1'b1;
        q.push_back(48'hB);
        step();
        n_vec++;
        if (snap_cnt !== 5'd2 || snap_sp !== 4'd1) begin
            n_err++;
            $display("FAIL pp_state: got sp=%0d cnt=%0d, expected 1 2", snap_sp, snap_cnt);
        end
        pop(48'hC);
        pop(48'hA);
        drain("pp");
        push_en = 1'b1;
        push_addr = 48'h55;
        pop_en = 1'b1;
        step();
        n_vec++;
        if (underflow !== 1'b1 || pred_valid !== 1'b0 || snap_cnt !== 5'd1) begin
            n_err++;
            $display("FAIL pp_empty: got uf=%b pv=%b cnt=%0d, expected 1 0 1", underflow, pred_valid, snap_cnt);
        end
        pop(48'h55);
        drain("pp_empty");
    endtask

    task automatic test_flush();
        do_reset();
        push(48'h10);
        push(48'h20);
        push(48'h30);
        push(48'h40);
        pop(48'h40);
        flush = 1'b1;
        flush_sp = 4'd1;
        flush_cnt = 5'd2;
        flush_top = 48'h20;
        push_en = 1'b1;
        push_addr = 48'hDEAD;
        step();
        n_vec++;
        if (snap_sp !== 4'd1 || snap_cnt !== 5'd2 || pred_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_restore: got sp=%0d cnt=%0d pv=%b, expected 1 2 0", snap_sp, snap_cnt, pred_valid);
        end
        pop(48'h20);
        pop(48'h10);
        drain("flush");
        flush = 1'b1;
        stall = 1'b1;
        pop_en = 1'b1;
        flush_sp = 4'd5;
        flush_cnt = 5'd31;
        step();
        n_vec++;
        if (snap_cnt !== 5'd16 || full !== 1'b1 || snap_sp !== 4'd5 || underflow !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clamp: got cnt=%0d full=%b sp=%0d uf=%b, expected 16 1 5 0", snap_cnt, full, snap_sp, underflow);
        end
    endtask

    task automatic test_repair();
        do_reset();
        push(48'h10);
        push(48'h20);
        pop(48'h20);
        push(48'h99);
        flush = 1'b1;
        flush_sp = 4'd1;
        flush_cnt = 5'd2;
        flush_top = 48'h20;
        step();
`ifdef RSTACK_REPAIR_EN
        pop(48'h20);
`else
        pop(48'h99);
`endif
        pop(48'h10);
        drain("repair");
    endtask

    task automatic test_async_reset();
        do_reset();
        push(48'h77);
        pop(48'h77);
        n_vec++;
        if (pred_valid !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre: got pv=%b, expected 1", pred_valid);
        end
        q.delete();
        rst = 1'b0;
        #1;
        n_vec++;
        if (pred_valid !== 1'b0 || snap_cnt !== 5'd0 || snap_sp !== 4'd15) begin
            n_err++;
            $display("FAIL arst_clear: got pv=%b cnt=%0d sp=%0d, expected 0 0 15", pred_valid, snap_cnt, snap_sp);
        end
        #1;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_wrap();
        test_underflow();
        test_push_pop();
        test_flush();
        test_repair();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
